// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//  Final pipeline stage, fed by the memory stage. Each accepted instruction
//  drives the scalar RF write port, the CC write port and/or the vector RF write
//  port back to decode. It also drives busy-bit clear pulses and a retired
//  instruction count. Vector results are written one LANE_WIDTH lane per cycle.
//  O_WBStall holds the memory stage until the last lane has been written.
//  All state changes on the falling edge of I_CLOCK.
//
// Ports
//  I_CLOCK, I_RESET         clock (negedge active), synchronous active-high reset
//  I_LOCK, I_MEM_Valid      input qualifiers; both 1 (and not stalled) => accept
//  I_RegWEn/I_VRegWEn/I_CCWEn  write requests for scalar RF / vector RF / CC
//  I_DestRegIdx, I_DestValue   scalar destination index and data
//  I_DestVRegIdx, I_VecDestValue  vector destination index and full vector data
//  I_CCValue                condition codes {N,Z,P}
//  O_WBStall                1 while a vector is being serialised
//  O_RegWEn, O_DestRegIdx, O_DestValue, O_ClrBusyEn   scalar write + busy clear
//  O_CCWEn, O_CCValue       CC write
//  O_VRegWEn, O_DestVRegIdx, O_VLaneIdx, O_VLaneData  vector lane write
//  O_ClrVBusyEn             vector busy clear, pulsed with the last lane
//  O_RetireCount            instructions retired since reset (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int REG_WIDTH     = 16,
    parameter int VREG_WIDTH    = 64,
    parameter int VREG_ID_WIDTH = 6,
    parameter int LANE_WIDTH    = 16
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_LOCK,
    input  logic                     I_MEM_Valid,
    input  logic                     I_RegWEn,
    input  logic                     I_VRegWEn,
    input  logic                     I_CCWEn,
    input  logic [3:0]               I_DestRegIdx,
    input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
    input  logic [REG_WIDTH-1:0]     I_DestValue,
    input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
    input  logic [2:0]               I_CCValue,
    output logic                     O_WBStall,
    output logic                     O_RegWEn,
    output logic [3:0]               O_DestRegIdx,
    output logic [REG_WIDTH-1:0]     O_DestValue,
    output logic                     O_CCWEn,
    output logic [2:0]               O_CCValue,
    output logic                     O_VRegWEn,
    output logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx,
    output logic [((VREG_WIDTH/LANE_WIDTH) > 1 ? $clog2(VREG_WIDTH/LANE_WIDTH) : 1)-1:0] O_VLaneIdx,
    output logic [LANE_WIDTH-1:0]    O_VLaneData,
    output logic                     O_ClrBusyEn,
    output logic                     O_ClrVBusyEn,
    output logic [31:0]              O_RetireCount
);

    localparam int LANES      = VREG_WIDTH / LANE_WIDTH;
    localparam int LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        VWRITE = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [LANE_IDX_W-1:0]   lane_cnt_r, lane_cnt_s;
    // Captured vector, shifted down one lane per write so the next lane is
    // always in the low bits (avoids a variable part-select mux).
    logic [VREG_WIDTH-1:0]   vec_r, vec_s;

    logic                     accept_s;
    logic                     reg_wen_s, clr_busy_s, cc_wen_s, vreg_wen_s, clr_vbusy_s;
    logic [3:0]               dest_idx_s;
    logic [REG_WIDTH-1:0]     dest_val_s;
    logic [2:0]               cc_val_s;
    logic [VREG_ID_WIDTH-1:0] vidx_s;
    logic [LANE_IDX_W-1:0]    lane_idx_s;
    logic [LANE_WIDTH-1:0]    lane_data_s;
    logic [31:0]              retire_s;

    // Stall is a pure decode of the registered state.
    assign O_WBStall = (state_r == VWRITE);
    assign accept_s  = I_LOCK & I_MEM_Valid & ~O_WBStall;

    // Next-state and next-output logic; strobes default low, data holds.
    always_comb begin
        state_s     = state_r;
        lane_cnt_s  = lane_cnt_r;
        vec_s       = vec_r;
        reg_wen_s   = 1'b0;
        clr_busy_s  = 1'b0;
        cc_wen_s    = 1'b0;
        vreg_wen_s  = 1'b0;
        clr_vbusy_s = 1'b0;
        dest_idx_s  = O_DestRegIdx;
        dest_val_s  = O_DestValue;
        cc_val_s    = O_CCValue;
        vidx_s      = O_DestVRegIdx;
        lane_idx_s  = O_VLaneIdx;
        lane_data_s = O_VLaneData;
        retire_s    = O_RetireCount;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (I_RegWEn) begin
                        reg_wen_s  = 1'b1;
                        clr_busy_s = 1'b1;
                        dest_idx_s = I_DestRegIdx;
                        dest_val_s = I_DestValue;
                    end else begin
                        reg_wen_s  = 1'b0;
                    end
                    if (I_CCWEn) begin
                        cc_wen_s = 1'b1;
                        cc_val_s = I_CCValue;
                    end else begin
                        cc_wen_s = 1'b0;
                    end
                    if (I_VRegWEn) begin
                        vreg_wen_s  = 1'b1;
                        vidx_s      = I_DestVRegIdx;
                        lane_idx_s  = '0;
                        lane_data_s = I_VecDestValue[LANE_WIDTH-1:0];
                        vec_s       = I_VecDestValue >> LANE_WIDTH;
                        if (LANES > 1) begin
                            state_s    = VWRITE;
                            lane_cnt_s = LANE_IDX_W'(1);
                        end else begin
                            // Single-lane vector completes in this cycle.
                            clr_vbusy_s = 1'b1;
                            retire_s    = O_RetireCount + 32'd1;
                        end
                    end else begin
                        retire_s = O_RetireCount + 32'd1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            VWRITE: begin
                // Inputs are ignored here; upstream is held by O_WBStall.
                vreg_wen_s  = 1'b1;
                lane_idx_s  = lane_cnt_r;
                lane_data_s = vec_r[LANE_WIDTH-1:0];
                vec_s       = vec_r >> LANE_WIDTH;
                if (lane_cnt_r == LAST_LANE) begin
                    clr_vbusy_s = 1'b1;
                    retire_s    = O_RetireCount + 32'd1;
                    lane_cnt_s  = '0;
                    state_s     = IDLE;
                end else begin
                    lane_cnt_s  = lane_cnt_r + LANE_IDX_W'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                lane_cnt_s = '0;
            end
        endcase
    end

    // State and output registers, updated on the falling clock edge.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            state_r       <= IDLE;
            lane_cnt_r    <= '0;
            vec_r         <= '0;
            O_RegWEn      <= 1'b0;
            O_ClrBusyEn   <= 1'b0;
            O_CCWEn       <= 1'b0;
            O_VRegWEn     <= 1'b0;
            O_ClrVBusyEn  <= 1'b0;
            O_DestRegIdx  <= 4'd0;
            O_DestValue   <= '0;
            O_CCValue     <= 3'd0;
            O_DestVRegIdx <= '0;
            O_VLaneIdx    <= '0;
            O_VLaneData   <= '0;
            O_RetireCount <= 32'd0;
        end else begin
            state_r       <= state_s;
            lane_cnt_r    <= lane_cnt_s;
            vec_r         <= vec_s;
            O_RegWEn      <= reg_wen_s;
            O_ClrBusyEn   <= clr_busy_s;
            O_CCWEn       <= cc_wen_s;
            O_VRegWEn     <= vreg_wen_s;
            O_ClrVBusyEn  <= clr_vbusy_s;
            O_DestRegIdx  <= dest_idx_s;
            O_DestValue   <= dest_val_s;
            O_CCValue     <= cc_val_s;
            O_DestVRegIdx <= vidx_s;
            O_VLaneIdx    <= lane_idx_s;
            O_VLaneData   <= lane_data_s;
            O_RetireCount <= retire_s;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//  Scoreboard bench for writeback_stage (LANES = 4). Expected writes are queued
//  when an instruction is driven and compared when the DUT strobes them.
//  DUT state changes on negedge; outputs are sampled on posedge.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET, I_LOCK, I_MEM_Valid, I_RegWEn, I_VRegWEn, I_CCWEn;
    logic [3:0]  I_DestRegIdx;
    logic [5:0]  I_DestVRegIdx;
    logic [15:0] I_DestValue;
    logic [63:0] I_VecDestValue;
    logic [2:0]  I_CCValue;
    logic        O_WBStall, O_RegWEn, O_CCWEn, O_VRegWEn, O_ClrBusyEn, O_ClrVBusyEn;
    logic [3:0]  O_DestRegIdx;
    logic [15:0] O_DestValue;
    logic [2:0]  O_CCValue;
    logic [5:0]  O_DestVRegIdx;
    logic [1:0]  O_VLaneIdx;
    logic [15:0] O_VLaneData;
    logic [31:0] O_RetireCount;

    writeback_stage dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_MEM_Valid(I_MEM_Valid),
        .I_RegWEn(I_RegWEn), .I_VRegWEn(I_VRegWEn), .I_CCWEn(I_CCWEn),
        .I_DestRegIdx(I_DestRegIdx), .I_DestVRegIdx(I_DestVRegIdx),
        .I_DestValue(I_DestValue), .I_VecDestValue(I_VecDestValue), .I_CCValue(I_CCValue),
        .O_WBStall(O_WBStall), .O_RegWEn(O_RegWEn), .O_DestRegIdx(O_DestRegIdx),
        .O_DestValue(O_DestValue), .O_CCWEn(O_CCWEn), .O_CCValue(O_CCValue),
        .O_VRegWEn(O_VRegWEn), .O_DestVRegIdx(O_DestVRegIdx), .O_VLaneIdx(O_VLaneIdx),
        .O_VLaneData(O_VLaneData), .O_ClrBusyEn(O_ClrBusyEn), .O_ClrVBusyEn(O_ClrVBusyEn),
        .O_RetireCount(O_RetireCount)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [3:0] idx; logic [15:0] val; logic [31:0] rc; } s_ent_t;
    typedef struct { logic [2:0] cc; logic with_reg; logic [31:0] rc; } c_ent_t;
    typedef struct { logic [5:0] vidx; logic [1:0] lane; logic [15:0] data;
                     logic last; logic stall; logic [31:0] rc; } v_ent_t;

    s_ent_t sq[$];
    c_ent_t cq[$];
    v_ent_t vq[$];
    logic [31:0] rc_model;
    s_ent_t se;
    c_ent_t ce;
    v_ent_t ve;

    // Monitor: every strobe must match the head of its expected queue.
    always @(posedge I_CLOCK) begin
        if (O_RegWEn) begin
            if (sq.size() == 0) begin
                check_val("reg_spurious", O_RegWEn, 0);
            end else begin
                se = sq.pop_front();
                check_val("reg_idx", O_DestRegIdx, se.idx);
                check_val("reg_val", O_DestValue, se.val);
                check_val("reg_clrbusy", O_ClrBusyEn, 1);
                check_val("reg_retire", O_RetireCount, se.rc);
            end
        end else begin
            check_val("clrbusy_idle", O_ClrBusyEn, 0);
        end
        if (O_CCWEn) begin
            if (cq.size() == 0) begin
                check_val("cc_spurious", O_CCWEn, 0);
            end else begin
                ce = cq.pop_front();
                check_val("cc_val", O_CCValue, ce.cc);
                check_val("cc_with_reg", O_RegWEn, ce.with_reg);
                check_val("cc_retire", O_RetireCount, ce.rc);
            end
        end
        if (O_VRegWEn) begin
            if (vq.size() == 0) begin
                check_val("vlane_spurious", O_VRegWEn, 0);
            end else begin
                ve = vq.pop_front();
                check_val("v_idx", O_DestVRegIdx, ve.vidx);
                check_val("v_lane", O_VLaneIdx, ve.lane);
                check_val("v_data", O_VLaneData, ve.data);
                check_val("v_clrvbusy", O_ClrVBusyEn, ve.last);
                check_val("v_stall", O_WBStall, ve.stall);
                check_val("v_retire", O_RetireCount, ve.rc);
            end
        end else begin
            check_val("clrvbusy_idle", O_ClrVBusyEn, 0);
        end
    end

    task automatic idle_inputs();
        I_LOCK = 1'b1; I_MEM_Valid = 1'b0; I_RegWEn = 1'b0; I_VRegWEn = 1'b0; I_CCWEn = 1'b0;
        I_DestRegIdx = 4'd0; I_DestVRegIdx = 6'd0; I_DestValue = 16'd0;
        I_VecDestValue = 64'd0; I_CCValue = 3'd0;
    endtask

    // Drive one non-vector instruction for one cycle (accepted at next negedge).
    task automatic issue(input logic reg_en, input logic cc_en, input logic [3:0] idx,
                         input logic [15:0] val, input logic [2:0] cc);
        I_LOCK = 1'b1; I_MEM_Valid = 1'b1; I_RegWEn = reg_en; I_CCWEn = cc_en;
        I_VRegWEn = 1'b0; I_DestRegIdx = idx; I_DestValue = val; I_CCValue = cc;
        rc_model = rc_model + 32'd1;
        if (reg_en) sq.push_back('{idx, val, rc_model});
        if (cc_en) cq.push_back('{cc, reg_en, rc_model});
        @(negedge I_CLOCK); #1;
    endtask

    // Drive a vector write and hold it for the whole 4-cycle occupancy.
    task automatic issue_vec(input logic [5:0] vidx, input logic [63:0] val, input int nlanes);
        I_LOCK = 1'b1; I_MEM_Valid = 1'b1; I_RegWEn = 1'b0; I_CCWEn = 1'b0;
        I_VRegWEn = 1'b1; I_DestVRegIdx = vidx; I_VecDestValue = val;
        for (int k = 0; k < nlanes; k++) begin
            vq.push_back('{vidx, k[1:0], val[k*16 +: 16], (k == 3), (k != 3),
                           (k == 3) ? rc_model + 32'd1 : rc_model});
        end
        if (nlanes == 4) rc_model = rc_model + 32'd1;
        repeat (nlanes) begin
            @(negedge I_CLOCK); #1;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge I_CLOCK); #1;
        end
    endtask

    initial begin
        rc_model = 32'd0;
        idle_inputs();
        I_RESET = 1'b1;
        wait_cycles(3);
        I_RESET = 1'b0;
        @(posedge I_CLOCK);
        check_val("rst_regwen", O_RegWEn, 0);
        check_val("rst_vregwen", O_VRegWEn, 0);
        check_val("rst_stall", O_WBStall, 0);
        check_val("rst_retire", O_RetireCount, 0);
        check_val("rst_destval", O_DestValue, 0);
        @(negedge I_CLOCK); #1;

        // Single scalar write.
        issue(1'b1, 1'b0, 4'd5, 16'h1234, 3'd0);
        idle_inputs();
        wait_cycles(2);
        check_val("t1_retire", O_RetireCount, rc_model);
        check_val("t1_idx_hold", O_DestRegIdx, 5);

        // Vector write held during stall, then back-to-back scalar after last lane.
        issue_vec(6'd3, 64'hDDDD_CCCC_BBBB_AAAA, 4);
        issue(1'b1, 1'b0, 4'd9, 16'h0F0F, 3'd0);
        idle_inputs();
        wait_cycles(2);

        // Three back-to-back scalar ops.
        issue(1'b1, 1'b0, 4'd1, 16'h1111, 3'd0);
        issue(1'b1, 1'b0, 4'd2, 16'h2222, 3'd0);
        issue(1'b1, 1'b0, 4'd3, 16'h3333, 3'd0);
        idle_inputs();
        wait_cycles(2);
        check_val("t3_retire", O_RetireCount, rc_model);

        // Valid with no write enables retires silently.
        issue(1'b0, 1'b0, 4'd0, 16'h0000, 3'd0);
        idle_inputs();
        wait_cycles(2);
        check_val("nowrite_retire", O_RetireCount, rc_model);

        // CC + scalar in the same cycle; then CC only.
        issue(1'b1, 1'b1, 4'd7, 16'hBEEF, 3'b010);
        issue(1'b0, 1'b1, 4'd0, 16'h0000, 3'b100);
        idle_inputs();
        wait_cycles(2);

        // Gating by I_LOCK and I_MEM_Valid.
        I_LOCK = 1'b0; I_MEM_Valid = 1'b1; I_RegWEn = 1'b1; I_CCWEn = 1'b1;
        I_VRegWEn = 1'b1; I_DestRegIdx = 4'd12; I_DestValue = 16'hDEAD;
        wait_cycles(2);
        I_LOCK = 1'b1; I_MEM_Valid = 1'b0;
        wait_cycles(2);
        idle_inputs();
        @(posedge I_CLOCK);
        check_val("gate_retire", O_RetireCount, rc_model);
        check_val("gate_stall", O_WBStall, 0);
        @(negedge I_CLOCK); #1;

        // Reset after lane 1 aborts the rest of the vector.
        issue_vec(6'd42, 64'h4444_3333_2222_1111, 2);
        I_RESET = 1'b1;
        idle_inputs();
        @(negedge I_CLOCK); #1;
        I_RESET = 1'b0;
        rc_model = 32'd0;
        @(posedge I_CLOCK);
        check_val("mid_rst_vwen", O_VRegWEn, 0);
        check_val("mid_rst_vidx", O_DestVRegIdx, 0);
        check_val("mid_rst_vdata", O_VLaneData, 0);
        check_val("mid_rst_stall", O_WBStall, 0);
        check_val("mid_rst_retire", O_RetireCount, 0);
        @(negedge I_CLOCK); #1;
        wait_cycles(3);
        issue(1'b1, 1'b0, 4'd4, 16'hA5A5, 3'd0);
        idle_inputs();
        wait_cycles(3);

        @(posedge I_CLOCK);
        check_val("end_retire", O_RetireCount, rc_model);
        check_val("end_sq_left", sq.size(), 0);
        check_val("end_cq_left", cq.size(), 0);
        check_val("end_vq_left", vq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
